// File: rtl/ysyx_icache.sv
// ---------------------------------------------------------------------------
// ysyx_icache
//   Direct-mapped, read-only instruction cache between the IFU and the bus.
//   Hits are answered one cycle after the request from on-chip line storage.
//   Misses refill a whole line word-by-word over the bus IFU read port.
//   Fetches inside the uncached window bypass the line storage with a single
//   bus read. fence.i invalidates every line.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   ifu_araddr      fetch address (word aligned), held while ifu_arvalid
//   ifu_arvalid     fetch request, held until ifu_rvalid_o
//   ifu_rdata_o     instruction word, valid with ifu_rvalid_o
//   ifu_rvalid_o    one-cycle response pulse
//   fence_i         one-cycle pulse, invalidate all lines
//   bus_araddr_o    word address to the bus
//   bus_arvalid_o   bus read request, held until bus_rvalid
//   bus_rdata       bus read data
//   bus_rvalid      one-cycle bus data pulse
//   perf_hit_o      wrapping hit counter
//   perf_miss_o     wrapping miss counter (bypass reads included)
// ---------------------------------------------------------------------------
module ysyx_icache #(
  parameter int                ADDR_W      = 32,
  parameter int                OFFSET_W    = 4,
  parameter int                INDEX_W     = 4,
  parameter logic [ADDR_W-1:0] BYPASS_BASE = 32'h0f00_0000,
  parameter logic [ADDR_W-1:0] BYPASS_MASK = 32'hff00_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [31:0]       ifu_rdata_o,
  output logic              ifu_rvalid_o,
  input  logic              fence_i,
  output logic [ADDR_W-1:0] bus_araddr_o,
  output logic              bus_arvalid_o,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_rvalid,
  output logic [31:0]       perf_hit_o,
  output logic [31:0]       perf_miss_o
);

  localparam int TAG_W  = ADDR_W - OFFSET_W - INDEX_W;
  localparam int WORD_W = OFFSET_W - 2;
  localparam int LINES  = 1 << INDEX_W;
  localparam int WORDS  = 1 << WORD_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_BYPASS,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  // Line storage: tags and data are never reset, only the valid bits are.
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES*WORDS];

  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_cnt;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_fencePend;
  logic              r_dropped;
  logic [31:0]       r_hitCnt;
  logic [31:0]       r_missCnt;

  logic [INDEX_W-1:0]        w_reqIdx;
  logic [TAG_W-1:0]          w_reqTag;
  logic [INDEX_W+WORD_W-1:0] w_reqSlot;
  logic [INDEX_W-1:0]        w_addrIdx;
  logic [TAG_W-1:0]          w_addrTag;
  logic [WORD_W-1:0]         w_addrWord;
  logic                      w_bypass;
  logic                      w_lookupHit;
  logic                      w_accHit;
  logic                      w_accMiss;
  logic                      w_accByp;
  logic                      w_beat;
  logic                      w_install;
  logic                      w_respDone;

  assign w_reqIdx   = ifu_araddr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_reqTag   = ifu_araddr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign w_reqSlot  = {w_reqIdx, ifu_araddr[OFFSET_W-1:2]};
  assign w_addrIdx  = r_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_addrTag  = r_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign w_addrWord = r_addr[OFFSET_W-1:2];

  assign w_bypass = (ifu_araddr & BYPASS_MASK) == BYPASS_BASE;

  // A fence.i arriving with the request forces the lookup to miss.
  assign w_lookupHit = r_valid[w_reqIdx] && (r_tag[w_reqIdx] == w_reqTag) && !fence_i;

  assign ifu_rdata_o  = r_rdata;
  assign ifu_rvalid_o = r_rvalid;
  assign perf_hit_o   = r_hitCnt;
  assign perf_miss_o  = r_missCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    bus_arvalid_o = 1'b0;
    bus_araddr_o  = '0;
    w_accHit      = 1'b0;
    w_accMiss     = 1'b0;
    w_accByp      = 1'b0;
    w_beat        = 1'b0;
    w_install     = 1'b0;
    w_respDone    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ifu_arvalid) begin
          if (w_bypass) begin
            w_accByp    = 1'b1;
            w_stateNext = S_BYPASS;
          end else if (w_lookupHit) begin
            w_accHit = 1'b1;
          end else begin
            w_accMiss   = 1'b1;
            w_stateNext = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        bus_arvalid_o = 1'b1;
        bus_araddr_o  = {r_addr[ADDR_W-1:OFFSET_W], r_cnt, 2'b00};
        if (bus_rvalid) begin
          w_beat = 1'b1;
          if (r_cnt == '1) begin
            w_install   = 1'b1;
            w_stateNext = S_RESP;
          end
        end
      end
      S_BYPASS: begin
        bus_arvalid_o = 1'b1;
        bus_araddr_o  = r_addr;
        if (bus_rvalid) begin
          w_beat      = 1'b1;
          w_stateNext = S_RESP;
        end
      end
      S_RESP: begin
        w_respDone  = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Request capture, response generation, valid bits, fence bookkeeping and
  // perf counters. The requested word is captured as its beat passes, so the
  // response does not need a second array read. A request dropped by the IFU
  // while the bus is busy still completes, but its response is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_fencePend <= 1'b0;
      r_dropped   <= 1'b0;
      r_hitCnt    <= '0;
      r_missCnt   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      if (r_state == S_IDLE && ifu_arvalid) begin
        r_addr    <= ifu_araddr;
        r_cnt     <= '0;
        r_dropped <= 1'b0;
      end
      if (w_accHit) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_data[w_reqSlot];
        r_hitCnt <= r_hitCnt + 32'd1;
      end
      if (w_accMiss || w_accByp) begin
        r_missCnt <= r_missCnt + 32'd1;
      end
      if ((r_state == S_REFILL || r_state == S_BYPASS) && !ifu_arvalid) begin
        r_dropped <= 1'b1;
      end
      if (w_beat) begin
        if (r_state == S_BYPASS || r_cnt == w_addrWord) begin
          r_rdata <= bus_rdata;
        end
        if (r_state == S_REFILL) begin
          r_cnt <= r_cnt + WORD_W'(1);
        end
        if (r_state == S_BYPASS || w_install) begin
          r_rvalid <= ifu_arvalid && !r_dropped;
        end
      end
      if (w_install && !r_fencePend && !fence_i) begin
        r_valid[w_addrIdx] <= 1'b1;
      end
      if (fence_i) begin
        if (r_state == S_IDLE) begin
          r_valid <= '0;
        end else begin
          r_fencePend <= 1'b1;
        end
      end
      if (w_respDone) begin
        if (r_fencePend || fence_i) begin
          r_valid <= '0;
        end
        r_fencePend <= 1'b0;
      end
    end
  end

  // Line storage writes: each refill beat lands in its word slot and the tag
  // is written together with the last beat.
  always_ff @(posedge clk) begin
    if (w_beat && r_state == S_REFILL) begin
      r_data[{w_addrIdx, r_cnt}] <= bus_rdata;
    end
    if (w_install) begin
      r_tag[w_addrIdx] <= w_addrTag;
    end
  end

endmodule

// File: tb/tb_ysyx_icache.sv
// ---------------------------------------------------------------------------
// tb_ysyx_icache
//   Directed bench for ysyx_icache: cold miss, hit stream, conflict refill,
//   bypass reads, fence.i during refill and in IDLE, dropped request and
//   reset in the middle of a refill. Inputs change and outputs are sampled
//   1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_ysyx_icache;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic [31:0] ifu_rdata_o;
  logic        ifu_rvalid_o;
  logic        fence_i;
  logic [31:0] bus_araddr_o;
  logic        bus_arvalid_o;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic [31:0] perf_hit_o;
  logic [31:0] perf_miss_o;

  int errors = 0;
  int checks = 0;
  int expHit = 0;
  int expMiss = 0;

  ysyx_icache dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_araddr   (ifu_araddr),
    .ifu_arvalid  (ifu_arvalid),
    .ifu_rdata_o  (ifu_rdata_o),
    .ifu_rvalid_o (ifu_rvalid_o),
    .fence_i      (fence_i),
    .bus_araddr_o (bus_araddr_o),
    .bus_arvalid_o(bus_arvalid_o),
    .bus_rdata    (bus_rdata),
    .bus_rvalid   (bus_rvalid),
    .perf_hit_o   (perf_hit_o),
    .perf_miss_o  (perf_miss_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against the bench's own expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advances to 1 unit after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Checks the pending bus request, then answers it with one data beat.
  task automatic busBeat(input logic [31:0] expAddr, input logic [31:0] data);
    checkOutput("bus_arvalid", {31'd0, bus_arvalid_o}, 32'd1);
    checkOutput("bus_araddr", bus_araddr_o, expAddr);
    bus_rvalid = 1'b1;
    bus_rdata  = data;
    applyStimulus();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'hdead_beef;
  endtask

  // Issues a fetch that must miss, refills the line with seed+0..seed+3 and
  // checks the response. fenceBeat/dropBeat select a beat (0..3) on which
  // fence_i is pulsed or ifu_arvalid is dropped; -1 means never.
  task automatic missFetch(input logic [31:0] addr, input logic [31:0] seed,
                           input int fenceBeat, input int dropBeat,
                           input logic expectResp);
    logic [31:0] lineBase;
    lineBase    = {addr[31:4], 4'h0};
    ifu_araddr  = addr;
    ifu_arvalid = 1'b1;
    applyStimulus();
    fence_i = 1'b0;
    expMiss++;
    checkOutput("miss_no_rvalid", {31'd0, ifu_rvalid_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == fenceBeat) fence_i = 1'b1;
      if (i == dropBeat) ifu_arvalid = 1'b0;
      busBeat(lineBase + 32'(i * 4), seed + 32'(i));
      fence_i = 1'b0;
    end
    checkOutput("miss_rvalid", {31'd0, ifu_rvalid_o}, {31'd0, expectResp});
    if (expectResp) checkOutput("miss_rdata", ifu_rdata_o, seed + 32'(addr[3:2]));
    checkOutput("miss_count", perf_miss_o, 32'(expMiss));
    ifu_arvalid = 1'b0;
    applyStimulus();
    checkOutput("miss_rvalid_end", {31'd0, ifu_rvalid_o}, 32'd0);
  endtask

  // Issues a single fetch that must hit with the given word.
  task automatic hitFetch(input logic [31:0] addr, input logic [31:0] expData);
    ifu_araddr  = addr;
    ifu_arvalid = 1'b1;
    applyStimulus();
    expHit++;
    checkOutput("hit_rvalid", {31'd0, ifu_rvalid_o}, 32'd1);
    checkOutput("hit_rdata", ifu_rdata_o, expData);
    checkOutput("hit_no_bus", {31'd0, bus_arvalid_o}, 32'd0);
    ifu_arvalid = 1'b0;
    applyStimulus();
    checkOutput("hit_count", perf_hit_o, 32'(expHit));
  endtask

  initial begin
    rst         = 1'b1;
    ifu_araddr  = '0;
    ifu_arvalid = 1'b0;
    fence_i     = 1'b0;
    bus_rdata   = '0;
    bus_rvalid  = 1'b0;

    // Reset state.
    #1;
    checkOutput("rst_rvalid", {31'd0, ifu_rvalid_o}, 32'd0);
    checkOutput("rst_rdata", ifu_rdata_o, 32'd0);
    checkOutput("rst_bus_arvalid", {31'd0, bus_arvalid_o}, 32'd0);
    checkOutput("rst_bus_araddr", bus_araddr_o, 32'd0);
    checkOutput("rst_perf_hit", perf_hit_o, 32'd0);
    checkOutput("rst_perf_miss", perf_miss_o, 32'd0);
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // 1: cold miss on word 1 of line 0x3000_0000.
    $display("[TB] cold miss");
    missFetch(32'h3000_0004, 32'ha000_0000, -1, -1, 1'b1);

    // 2: back-to-back hits across the whole line.
    $display("[TB] hit stream");
    ifu_araddr  = 32'h3000_0000;
    ifu_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      expHit++;
      checkOutput("stream_rvalid", {31'd0, ifu_rvalid_o}, 32'd1);
      checkOutput("stream_rdata", ifu_rdata_o, 32'ha000_0000 + 32'(i));
      checkOutput("stream_no_bus", {31'd0, bus_arvalid_o}, 32'd0);
      ifu_araddr = 32'h3000_0000 + 32'((i + 1) * 4);
      if (i == 3) ifu_arvalid = 1'b0;
    end
    applyStimulus();
    checkOutput("stream_rvalid_end", {31'd0, ifu_rvalid_o}, 32'd0);
    checkOutput("stream_hits", perf_hit_o, 32'd4);

    // 3: conflict on index 0, then the original line is reloaded.
    $display("[TB] conflict");
    missFetch(32'h3000_0100, 32'hb000_0000, -1, -1, 1'b1);
    missFetch(32'h3000_0000, 32'ha000_0000, -1, -1, 1'b1);
    hitFetch(32'h3000_0008, 32'ha000_0002);

    // 4: two uncached reads, nothing installed.
    $display("[TB] bypass");
    for (int i = 0; i < 2; i++) begin
      ifu_araddr  = 32'h0f00_0010;
      ifu_arvalid = 1'b1;
      applyStimulus();
      expMiss++;
      busBeat(32'h0f00_0010, 32'hc000_0000 + 32'(i));
      checkOutput("byp_rvalid", {31'd0, ifu_rvalid_o}, 32'd1);
      checkOutput("byp_rdata", ifu_rdata_o, 32'hc000_0000 + 32'(i));
      ifu_arvalid = 1'b0;
      applyStimulus();
    end
    checkOutput("byp_miss", perf_miss_o, 32'(expMiss));
    checkOutput("byp_hit", perf_hit_o, 32'(expHit));

    // 5: fence.i on beat 2 still answers, but the line is not kept and all
    // other lines are gone too. Then fence.i arriving with a request in IDLE
    // forces that lookup to miss.
    $display("[TB] fence.i");
    missFetch(32'h3000_0048, 32'hd000_0000, 2, -1, 1'b1);
    missFetch(32'h3000_0040, 32'hd000_0000, -1, -1, 1'b1);
    missFetch(32'h3000_0000, 32'ha000_0000, -1, -1, 1'b1);
    hitFetch(32'h3000_0044, 32'hd000_0001);
    fence_i = 1'b1;
    missFetch(32'h3000_0000, 32'ha000_0000, -1, -1, 1'b1);
    hitFetch(32'h3000_000c, 32'ha000_0003);

    // 6: dropped request installs silently; reset mid-refill aborts.
    $display("[TB] abort and reset");
    missFetch(32'h3000_0080, 32'he000_0000, -1, 1, 1'b0);
    hitFetch(32'h3000_0084, 32'he000_0001);
    ifu_araddr  = 32'h3000_00c0;
    ifu_arvalid = 1'b1;
    applyStimulus();
    busBeat(32'h3000_00c0, 32'hf000_0000);
    checkOutput("pre_rst_bus_arvalid", {31'd0, bus_arvalid_o}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_bus_arvalid", {31'd0, bus_arvalid_o}, 32'd0);
    checkOutput("mid_rst_bus_araddr", bus_araddr_o, 32'd0);
    checkOutput("mid_rst_perf_miss", perf_miss_o, 32'd0);
    ifu_arvalid = 1'b0;
    applyStimulus();
    rst     = 1'b0;
    expHit  = 0;
    expMiss = 0;
    applyStimulus();
    missFetch(32'h3000_0084, 32'he100_0000, -1, -1, 1'b1);
    missFetch(32'h3000_00c0, 32'hf100_0000, -1, -1, 1'b1);
    checkOutput("post_rst_hit", perf_hit_o, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
